vlsu_meta_bcast_fifo: RTL and testbench

- Parametrised successor to the two-way meta-info broadcast inside the vector load unit.
- Accepts one global meta descriptor per handshake and replicates it to NrConsumers independent consumers (sequential-load, shuffle, mask, store-side units, ...).
- Each consumer has its own Depth-entry FIFO, so consumers drain at independent rates.
- Each accepted descriptor carries an instruction ID. A synchronous flush clears all in-flight state.

---
 rtl/vlsu_pkg.sv | 6 +
 rtl/vlsu_meta_bcast_fifo_if.sv | 15 +
 rtl/vlsu_meta_fifo_lane.sv | 103 ++++++++++
 rtl/vlsu_meta_bcast_fifo.sv | 77 +++++++
 tb/tb_vlsu_meta_bcast_fifo.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/vlsu_pkg.sv
// Shared constants for the vector load unit meta-info broadcast path.
package vlsu_pkg;

  localparam int unsigned VlsuMetaIdWidth = 4;

endpackage

// File: rtl/vlsu_meta_bcast_fifo_if.sv
// One descriptor stream: valid/ready handshake carrying a meta descriptor and its instruction ID.
interface vlsu_meta_bcast_fifo_if #(
  parameter type         meta_t  = logic,
  parameter int unsigned IdWidth = 4
);

  logic               valid;
  logic               ready;
  meta_t              meta;
  logic [IdWidth-1:0] id;

  modport master (output valid, meta, id, input  ready);
  modport slave  (input  valid, meta, id, output ready);

endinterface

// File: rtl/vlsu_meta_fifo_lane.sv
// Single consumer FIFO of the meta broadcast: Depth entries of descriptor + ID,
// optional zero-latency fall-through when empty.
module vlsu_meta_fifo_lane
  import vlsu_pkg::*;
#(
  parameter type         meta_t      = logic,
  parameter int unsigned Depth       = 2,
  parameter int unsigned IdWidth     = VlsuMetaIdWidth,
  parameter bit          FallThrough = 1'b0
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  meta_t                      meta_i,
  input  logic [IdWidth-1:0]         id_i,
  output logic                       can_accept_o,
  output logic [$clog2(Depth+1)-1:0] occupancy_o,
  vlsu_meta_bcast_fifo_if.master     out_if
);

  localparam int unsigned CntW = $clog2(Depth + 1);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  meta_t              mem_q    [Depth];
  meta_t              mem_d    [Depth];
  logic [IdWidth-1:0] id_mem_q [Depth];
  logic [IdWidth-1:0] id_mem_d [Depth];
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic empty, full, bypass, pop, store, pop_mem;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves one unassigned (no latches).
  always_comb begin
    empty  = (cnt_q == '0);
    full   = (cnt_q == CntW'(Depth));
    bypass = FallThrough && empty && push_i;

    out_if.valid = !empty || bypass;
    out_if.meta  = bypass ? meta_i : mem_q[rd_ptr_q];
    out_if.id    = bypass ? id_i   : id_mem_q[rd_ptr_q];

    // A full lane still accepts when its consumer pops this cycle.
    can_accept_o = !full || out_if.ready;

    pop     = out_if.valid && out_if.ready && !flush_i;
    store   = push_i && !(bypass && out_if.ready);
    pop_mem = pop && !bypass;

    mem_d    = mem_q;
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (store) begin
      mem_d[wr_ptr_q]    = meta_i;
      id_mem_d[wr_ptr_q] = id_i;
      wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_mem) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    unique case ({store, pop_mem})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    // Flush wins over any same-cycle push or pop; stale storage is left in place.
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  assign occupancy_o = cnt_q;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together at the edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      // NOTE: storage is reset as well so the descriptor outputs never show X; it is only Depth entries.
      for (int i = 0; i < int'(Depth); i++) begin
        mem_q[i]    <= '0;
        id_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
      id_mem_q <= id_mem_d;
    end
  end

endmodule

// File: rtl/vlsu_meta_bcast_fifo.sv
// Broadcasts each accepted meta descriptor, tagged with a rolling instruction ID,
// into NrConsumers independent FIFOs; input is accepted only when every lane can take it.
module vlsu_meta_bcast_fifo
  import vlsu_pkg::*;
#(
  parameter int unsigned NrConsumers = 2,
  parameter int unsigned Depth       = 2,
  parameter int unsigned IdWidth     = VlsuMetaIdWidth,
  parameter bit          FallThrough = 1'b0,
  parameter type         meta_glb_t  = logic
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic                                         flush_i,
  input  logic                                         meta_info_valid_i,
  output logic                                         meta_info_ready_o,
  input  meta_glb_t                                    meta_info_i,
  output logic      [NrConsumers-1:0]                  cons_valid_o,
  input  logic      [NrConsumers-1:0]                  cons_ready_i,
  output meta_glb_t                                    cons_o [NrConsumers],
  output logic      [NrConsumers-1:0][IdWidth-1:0]     cons_id_o,
  output logic                                         idle_o,
  output logic      [NrConsumers-1:0][$clog2(Depth+1)-1:0] occupancy_o
);

  logic [NrConsumers-1:0] can_accept;
  logic                   push;
  logic [IdWidth-1:0]     id_q, id_d;

  always_comb begin
    meta_info_ready_o = !flush_i && (&can_accept);
    push              = meta_info_valid_i && meta_info_ready_o;
    idle_o            = (occupancy_o == '0);

    id_d = id_q;
    if (flush_i) begin
      id_d = '0;
    end else if (push) begin
      id_d = id_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      id_q <= '0;
    end else begin
      id_q <= id_d;
    end
  end

  for (genvar k = 0; k < NrConsumers; k++) begin : g_lane
    vlsu_meta_bcast_fifo_if #(.meta_t(meta_glb_t), .IdWidth(IdWidth)) lane_if ();

    vlsu_meta_fifo_lane #(
      .meta_t      (meta_glb_t),
      .Depth       (Depth),
      .IdWidth     (IdWidth),
      .FallThrough (FallThrough)
    ) i_lane (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .flush_i      (flush_i),
      .push_i       (push),
      .meta_i       (meta_info_i),
      .id_i         (id_q),
      .can_accept_o (can_accept[k]),
      .occupancy_o  (occupancy_o[k]),
      .out_if       (lane_if)
    );

    assign lane_if.ready   = cons_ready_i[k];
    assign cons_valid_o[k] = lane_if.valid;
    assign cons_o[k]       = lane_if.meta;
    assign cons_id_o[k]    = lane_if.id;
  end

endmodule

// File: tb/tb_vlsu_meta_bcast_fifo.sv
// Directed bench: a registered 3x2 instance (IdWidth=2) and a fall-through 3x4 instance.
module tb_vlsu_meta_bcast_fifo;
  import vlsu_pkg::*;

  typedef logic [7:0] meta_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Instance A: NrConsumers=3, Depth=2, IdWidth=2, registered
  vlsu_meta_bcast_fifo_if #(.meta_t(meta_t), .IdWidth(2)) a_in ();
  logic              a_flush;
  logic [2:0]        a_cons_valid, a_cons_ready;
  meta_t             a_cons [3];
  logic [2:0][1:0]   a_cons_id;
  logic              a_idle;
  logic [2:0][1:0]   a_occ;

  vlsu_meta_bcast_fifo #(
    .NrConsumers(3), .Depth(2), .IdWidth(2), .FallThrough(1'b0), .meta_glb_t(meta_t)
  ) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
    .meta_info_valid_i(a_in.valid), .meta_info_ready_o(a_in.ready), .meta_info_i(a_in.meta),
    .cons_valid_o(a_cons_valid), .cons_ready_i(a_cons_ready), .cons_o(a_cons),
    .cons_id_o(a_cons_id), .idle_o(a_idle), .occupancy_o(a_occ)
  );

  // Instance B: NrConsumers=3, Depth=4, IdWidth=4, fall-through
  logic              b_flush, b_valid, b_ready;
  meta_t             b_meta;
  logic [2:0]        b_cons_valid, b_cons_ready;
  meta_t             b_cons [3];
  logic [2:0][3:0]   b_cons_id;
  logic              b_idle;
  logic [2:0][2:0]   b_occ;

  vlsu_meta_bcast_fifo #(
    .NrConsumers(3), .Depth(4), .IdWidth(4), .FallThrough(1'b1), .meta_glb_t(meta_t)
  ) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
    .meta_info_valid_i(b_valid), .meta_info_ready_o(b_ready), .meta_info_i(b_meta),
    .cons_valid_o(b_cons_valid), .cons_ready_i(b_cons_ready), .cons_o(b_cons),
    .cons_id_o(b_cons_id), .idle_o(b_idle), .occupancy_o(b_occ)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a_all(input string tag, input meta_t m, input int id);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.a%0d.meta", tag, k), a_cons[k], m);
      check($sformatf("%s.a%0d.id", tag, k), a_cons_id[k], id);
    end
  endtask

  task automatic chk_b_all(input string tag, input meta_t m, input int id);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("%s.b%0d.meta", tag, k), b_cons[k], m);
      check($sformatf("%s.b%0d.id", tag, k), b_cons_id[k], id);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    meta_t abc [3];
    abc[0] = 8'hA1; abc[1] = 8'hB2; abc[2] = 8'hC3;

    a_in.valid = 1'b0; a_in.meta = '0; a_in.id = '0; a_flush = 1'b0; a_cons_ready = '0;
    b_valid = 1'b0; b_meta = '0; b_flush = 1'b0; b_cons_ready = '0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst.a.ready", a_in.ready, 1);
    check("rst.a.idle", a_idle, 1);
    check("rst.a.valid", a_cons_valid, 3'b000);
    check("rst.a.occ", a_occ, 6'd0);
    check("rst.b.ready", b_ready, 1);
    check("rst.b.idle", b_idle, 1);
    check("rst.b.valid", b_cons_valid, 3'b000);
    next_cycle();

    // Back-to-back A,B,C with all consumers ready: one-cycle latency
    a_cons_ready = 3'b111;
    for (int i = 0; i <= 3; i++) begin
      a_in.valid = (i < 3);
      if (i < 3) a_in.meta = abc[i];
      @(negedge clk);
      check("b2b.ready", a_in.ready, 1);
      if (i == 0) begin
        check("b2b.valid0", a_cons_valid, 3'b000);
      end else begin
        check("b2b.valid", a_cons_valid, 3'b111);
        chk_a_all($sformatf("b2b%0d", i), abc[i-1], i - 1);
      end
      next_cycle();
    end
    @(negedge clk);
    check("b2b.idle", a_idle, 1);
    next_cycle();

    // Consumer 1 stalled; ID counter is at 3
    a_cons_ready = 3'b101; a_in.valid = 1'b1; a_in.meta = 8'hD0;
    @(negedge clk);
    check("stall.rdy0", a_in.ready, 1);
    next_cycle();
    a_in.meta = 8'hE0;
    @(negedge clk);
    check("stall.rdy1", a_in.ready, 1);
    check("stall.c1.meta", a_cons[1], 8'hD0);
    check("stall.c1.id", a_cons_id[1], 3);
    next_cycle();
    a_in.meta = 8'hF0;
    @(negedge clk);
    check("stall.rdy2", a_in.ready, 0);
    check("stall.occ1", a_occ[1], 2);
    check("stall.occ0", a_occ[0], 1);
    check("stall.c0.meta", a_cons[0], 8'hE0);
    check("stall.c0.id", a_cons_id[0], 0);
    next_cycle();
    @(negedge clk);
    check("stall.rdy3", a_in.ready, 0);
    check("stall.occ0b", a_occ[0], 0);
    check("stall.valid", a_cons_valid, 3'b010);
    next_cycle();
    a_cons_ready = 3'b111;
    @(negedge clk);
    check("stall.rdy4", a_in.ready, 1);
    check("stall.occ1b", a_occ[1], 2);
    next_cycle();
    a_in.valid = 1'b0;
    @(negedge clk);
    check("stall.occ1c", a_occ[1], 2);
    check("stall.c1.meta2", a_cons[1], 8'hE0);
    check("stall.c1.id2", a_cons_id[1], 0);
    check("stall.c0.meta2", a_cons[0], 8'hF0);
    check("stall.c0.id2", a_cons_id[0], 1);
    next_cycle();
    @(negedge clk);
    check("stall.c1.meta3", a_cons[1], 8'hF0);
    check("stall.c1.id3", a_cons_id[1], 1);
    check("stall.occ1d", a_occ[1], 1);
    check("stall.valid2", a_cons_valid, 3'b010);
    next_cycle();
    @(negedge clk);
    check("stall.idle", a_idle, 1);
    next_cycle();

    // Flush A (valid held high: must not be accepted), then ID wrap with IdWidth=2
    a_flush = 1'b1; a_in.valid = 1'b1; a_in.meta = 8'hEE;
    @(negedge clk);
    check("aflush.ready", a_in.ready, 0);
    next_cycle();
    a_flush = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      a_in.valid = (i < 6);
      a_in.meta  = meta_t'(8'h60 + i);
      @(negedge clk);
      check("wrap.ready", a_in.ready, 1);
      if (i == 0) begin
        check("wrap.valid0", a_cons_valid, 3'b000);
      end else begin
        chk_a_all($sformatf("wrap%0d", i), meta_t'(8'h60 + i - 1), (i - 1) % 4);
      end
      next_cycle();
    end
    a_in.valid = 1'b0;

    // Fall-through on B: zero latency, nothing stored
    b_cons_ready = 3'b111;
    for (int i = 0; i <= 3; i++) begin
      b_valid = (i < 3);
      if (i < 3) b_meta = abc[i];
      @(negedge clk);
      if (i < 3) begin
        check("ft.valid", b_cons_valid, 3'b111);
        chk_b_all($sformatf("ft%0d", i), abc[i], i);
        check("ft.occ", b_occ, 9'd0);
      end else begin
        check("ft.valid_end", b_cons_valid, 3'b000);
        check("ft.idle", b_idle, 1);
      end
      next_cycle();
    end

    // Flush on B with consumer 0 holding 3 entries (IDs 3,4,5)
    b_cons_ready = 3'b110;
    for (int i = 0; i < 3; i++) begin
      b_valid = 1'b1; b_meta = meta_t'(8'h90 + i);
      @(negedge clk);
      check("bfill.ready", b_ready, 1);
      check("bfill.c1.id", b_cons_id[1], 3 + i);
      next_cycle();
    end
    b_flush = 1'b1; b_meta = 8'hFF;
    @(negedge clk);
    check("bflush.ready", b_ready, 0);
    check("bflush.occ0", b_occ[0], 3);
    check("bflush.valid", b_cons_valid, 3'b001);
    check("bflush.c0.meta", b_cons[0], 8'h90);
    check("bflush.c0.id", b_cons_id[0], 3);
    next_cycle();
    b_flush = 1'b0; b_valid = 1'b0; b_cons_ready = 3'b111;
    @(negedge clk);
    check("bflush.occ", b_occ, 9'd0);
    check("bflush.idle", b_idle, 1);
    check("bflush.valid2", b_cons_valid, 3'b000);
    next_cycle();
    b_valid = 1'b1; b_meta = 8'h5A;
    @(negedge clk);
    check("bflush.nvalid", b_cons_valid, 3'b111);
    chk_b_all("bflush.next", 8'h5A, 0);
    next_cycle();
    b_valid = 1'b0;

    // Async reset with two entries queued in every lane of A
    a_cons_ready = 3'b000; a_in.valid = 1'b1; a_in.meta = 8'h70;
    next_cycle();
    a_in.meta = 8'h71;
    next_cycle();
    a_in.valid = 1'b0;
    @(negedge clk);
    check("arst.pre.occ", a_occ, {2'd2, 2'd2, 2'd2});
    check("arst.pre.valid", a_cons_valid, 3'b111);
    check("arst.pre.ready", a_in.ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid", a_cons_valid, 3'b000);
    check("arst.occ", a_occ, 6'd0);
    check("arst.idle", a_idle, 1);
    check("arst.ready", a_in.ready, 1);
    next_cycle();
    rst_n = 1'b1; a_cons_ready = 3'b111; a_in.valid = 1'b1; a_in.meta = 8'h33;
    next_cycle();
    a_in.valid = 1'b0;
    @(negedge clk);
    check("arst.post.valid", a_cons_valid, 3'b111);
    chk_a_all("arst.post", 8'h33, 0);
    next_cycle();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
